// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces a fetch after STARVE_LIMIT data grants.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] SMAX_C  = {SW{1'b1}};
    localparam bit STRICT_C = (STARVE_LIMIT == 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [SW-1:0]   scount_r;
    logic            d_req_s;
    logic            limit_ok_s;
    logic            grant_i_s;
    logic            grant_d_s;

    assign d_req_s    = dREN | dWEN;
    assign limit_ok_s = STRICT_C || (scount_r < LIMIT_C);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Starvation counter: counts data grants taken over a waiting fetch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scount_r <= {SW{1'b0}};
        end else if (grant_i_s) begin
            scount_r <= {SW{1'b0}};
        end else if ((state_r == IDLE) && !iREN) begin
            scount_r <= {SW{1'b0}};
        end else if (grant_d_s && (scount_r != SMAX_C)) begin
            scount_r <= scount_r + SW'(1);
        end else begin
            scount_r <= scount_r;
        end
    end

    // Arbitration, RAM drive and completion decode.
    always_comb begin
        next_state_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = 32'd0;
        ramstore     = 32'd0;
        ihit         = 1'b0;
        iload        = 32'd0;
        dhit         = 1'b0;
        dload        = 32'd0;
        case (state_r)
            IDLE: begin
                if (d_req_s && limit_ok_s) begin
                    next_state_s = DACCESS;
                    grant_d_s    = 1'b1;
                end else if (iREN) begin
                    next_state_s = IFETCH;
                    grant_i_s    = 1'b1;
                end else if (d_req_s) begin
                    next_state_s = DACCESS;
                    grant_d_s    = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                // A dropped request aborts even if the RAM answers this cycle.
                if (!iREN) begin
                    next_state_s = IDLE;
                end else if (ramready) begin
                    ihit         = 1'b1;
                    iload        = ramload;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = IFETCH;
                end
            end
            DACCESS: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                if (!d_req_s) begin
                    next_state_s = IDLE;
                end else if (ramready) begin
                    dhit         = 1'b1;
                    dload        = ramload;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DACCESS;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: stimulus queues expected hits, a negedge monitor retires them.
module tb_memory_arbiter;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        ihit;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    int tests;
    int failed;

    typedef struct {
        bit          is_d;
        bit          chk;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [3:0] lat;
    logic [3:0] rcnt;
    logic       force_rdy;

    memory_arbiter #(.STARVE_LIMIT(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return (a == 32'h0000_0040) ? 32'h8C01_0004 : (a ^ 32'h1234_5678);
    endfunction

    // RAM model: ready in the lat-th consecutive enabled cycle.
    assign ramload  = ram_val(ramaddr);
    assign ramready = force_rdy | ((ramREN | ramWEN) && (rcnt == lat - 4'd1));
    always @(posedge CLK) begin
        if (RST || !(ramREN | ramWEN)) rcnt <= 4'd0;
        else                           rcnt <= rcnt + 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit chk, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.chk  = chk;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every hit must match the oldest expected completion.
    always @(negedge CLK) begin
        if (ihit && dhit) check("ihit_dhit_exclusive", 32'd1, 32'd0);
        if (ihit || dhit) begin
            if (exp_q.size() == 0) begin
                check("unexpected_hit", {30'd0, dhit, ihit}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("hit_kind", 32'(dhit), 32'(e.is_d));
                if (e.chk) check("hit_data", dhit ? dload : iload, e.data);
            end
        end
    end

    initial begin
        logic [1:0]  sc;
        logic [31:0] want_addr;
        int          n_ren;
        int          n_hit;
        bit          pat[6];

        tests = 0; failed = 0;
        RST = 1'b1; iREN = 1'b0; iaddr = 32'd0; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'd0; dstore = 32'd0; lat = 4'd1; force_rdy = 1'b0;

        // Power-on reset
        tick(); tick();
        @(negedge CLK);
        check("rst_ramREN", 32'(ramREN), 32'd0);
        check("rst_ramWEN", 32'(ramWEN), 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_scount", 32'(dut.scount_r), 32'd0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_enables", {30'd0, ramREN, ramWEN}, 32'd0);
        check("post_rst_hits", {30'd0, ihit, dhit}, 32'd0);

        // Reset mid-DACCESS
        lat = 4'd5; dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h80;
        tick();
        @(negedge CLK);
        check("mr_grant_ramREN", 32'(ramREN), 32'd1);
        check("mr_grant_addr", ramaddr, 32'h100);
        check("mr_scount_inc", 32'(dut.scount_r), 32'd1);
        tick();
        RST = 1'b1; dREN = 1'b0; iREN = 1'b0;
        tick();
        @(negedge CLK);
        check("mr_ramREN", 32'(ramREN), 32'd0);
        check("mr_ramWEN", 32'(ramWEN), 32'd0);
        check("mr_scount", 32'(dut.scount_r), 32'd0);
        tick();
        RST = 1'b0;
        tick(); tick();

        // Lone fetch, 3-cycle RAM
        lat = 4'd3; iaddr = 32'h40; iREN = 1'b1;
        push(1'b0, 1'b1, 32'h8C01_0004);
        n_ren = 0; n_hit = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            if (ramREN) n_ren++;
            if (ihit) n_hit++;
            tick();
            if (n_hit > 0) iREN = 1'b0;
        end
        check("fetch_ramREN_cycles", 32'(n_ren), 32'd3);
        check("fetch_hit_count", 32'(n_hit), 32'd1);

        // Contention: data first, one IDLE cycle, then fetch
        lat = 4'd1; iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
        push(1'b1, 1'b1, ram_val(32'h100));
        push(1'b0, 1'b1, ram_val(32'h80));
        @(negedge CLK);
        check("ct_idle0", {30'd0, ramREN, ramWEN}, 32'd0);
        tick();
        @(negedge CLK);
        check("ct_d_addr", ramaddr, 32'h100);
        check("ct_dhit", 32'(dhit), 32'd1);
        tick();
        dREN = 1'b0;
        @(negedge CLK);
        check("ct_idle1", {30'd0, ramREN, ramWEN}, 32'd0);
        tick();
        @(negedge CLK);
        check("ct_i_addr", ramaddr, 32'h80);
        check("ct_ihit", 32'(ihit), 32'd1);
        tick();
        iREN = 1'b0;
        tick();

        // Write wins over read
        lat = 4'd2; dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        push(1'b1, 1'b0, 32'd0);
        tick();
        @(negedge CLK);
        check("wr_ramWEN", 32'(ramWEN), 32'd1);
        check("wr_ramREN", 32'(ramREN), 32'd0);
        check("wr_ramstore", ramstore, 32'hDEAD_BEEF);
        check("wr_ramaddr", ramaddr, 32'h200);
        check("wr_no_early_hit", 32'(dhit), 32'd0);
        tick();
        @(negedge CLK);
        check("wr_dhit", 32'(dhit), 32'd1);
        tick();
        dREN = 1'b0; dWEN = 1'b0;
        tick();

        // Starvation with limit 2: D D I D D I
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        lat = 4'd1; iaddr = 32'h300; daddr = 32'h3C0;
        for (int g = 0; g < 6; g++)
            push(pat[g], 1'b1, pat[g] ? ram_val(32'h3C0) : ram_val(32'h300));
        iREN = 1'b1; dREN = 1'b1;
        for (int g = 0; g < 6; g++) begin
            @(negedge CLK);
            sc = dut.scount_r;
            check("sv_idle", {30'd0, ramREN, ramWEN}, 32'd0);
            tick();
            @(negedge CLK);
            want_addr = pat[g] ? 32'h3C0 : 32'h300;
            check("sv_grant_addr", ramaddr, want_addr);
            if (!pat[g]) check("sv_scount_before_i", 32'(sc), 32'd2);
            tick();
        end
        iREN = 1'b0; dREN = 1'b0;
        tick();

        // Abort fetch; late ramready ignored
        lat = 4'd10; iaddr = 32'h40; iREN = 1'b1;
        tick();
        @(negedge CLK);
        check("ab_ramREN", 32'(ramREN), 32'd1);
        check("ab_ramaddr", ramaddr, 32'h40);
        tick();
        iREN = 1'b0; force_rdy = 1'b1;
        @(negedge CLK);
        check("ab_no_ihit", 32'(ihit), 32'd0);
        tick();
        @(negedge CLK);
        check("ab_idle_ramREN", 32'(ramREN), 32'd0);
        check("ab_late_no_ihit", 32'(ihit), 32'd0);
        tick();
        force_rdy = 1'b0;
        tick(); tick();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
